led_mode_scheduler: RTL and testbench
=====================================

# led_mode_scheduler

Arbitrates ownership of the LED display controller's mode select between four requesters: manual switch selection, an auto-cycling tour, demo mode and a thermal/clock alert override. It emits a registered 3-bit display mode plus ownership and status flags. It sits between the board switch/button inputs and system status signals on one side, and the LED display controller's mode input on the other. It replaces the direct switch-to-mode wiring.

## Interface
- DWELL_CYCLES, 100000000: cycles each mode is shown in auto-cycle (1 s at 100 MHz); must be ≥1.
- ALERT_HOLD_CYCLES, 50000000: minimum cycles an alert holds the display; must be ≥1.
- DEBOUNCE_CYCLES, 1000000: cycles btnNext must be stable before its debounced level changes; must be ≥1.
- clk  in  1  display clock.
- reset  in  1  reset, synchronous, active-high.
- switchMode  in  3  manual mode request.
- autoCycle  in  1  level; requests the auto-cycle tour.
- btnNext  in  1  raw asynchronous push button; advances the auto-cycle tour.
- clockLocked  in  1  clock manager lock.
- thermalThrottle  in  1  thermal throttle active.
- demoActive  in  1  demo mode running.
- demoPhase  in  3  current demo phase.
- displayMode  out  3  mode select to the LED display controller.
- owner  out  3  current owner: 0 INIT, 1 MANUAL, 2 AUTO, 3 DEMO, 4 ALERT.
- modeValid  out  1  high in every state except INIT.
- alertActive  out  1  high while owner is ALERT.
- modeChanged  out  1  one-cycle pulse whenever displayMode changes value.

## Operation
- States: INIT, MANUAL, AUTO, DEMO, ALERT. All outputs are registered. State and displayMode update in the same edge.
- Reset values: state INIT; displayMode 7 (heartbeat); owner 0; modeValid 0; alertActive 0; modeChanged 0.
- Reset also clears: auto index, dwell counter, hold counter, debounce counter, and synchronizer flops.
- INIT: displayMode 7. When clockLocked=1, go to the arbitrated state.
- Arbitration, evaluated each cycle outside INIT, in priority order:
  - clockLocked=0 → INIT (highest priority, from any state).
  - thermalThrottle rising edge (registered previous value) → ALERT.
  - Otherwise, if demoActive → DEMO.
  - Otherwise, if autoCycle → AUTO.
  - Otherwise → MANUAL.
- ALERT:
  - displayMode 0 (system status).
  - The hold counter loads ALERT_HOLD_CYCLES-1 on entry.
  - Exit only when the hold counter is 0 and thermalThrottle=0; then re-arbitrate.
  - A new rising edge while in ALERT reloads the hold counter.
  - Loss of clockLocked still wins → INIT.
- DEMO: displayMode = 3 when demoPhase[0]=0, 4 when demoPhase[0]=1. Tracks demoPhase every cycle.
- AUTO:
  - displayMode = auto index. Tour order 0,1,2,3,4, wrapping 4→0; modes 5–7 are never visited.
  - The dwell counter counts to DWELL_CYCLES-1, then advances the index and restarts.
  - A btnNext pulse advances the index and restarts the dwell counter.
  - A pulse coincident with dwell expiry advances by one only.
  - The auto index is retained while not in AUTO. Re-entry resumes at the retained index with dwell restarted at 0.
- MANUAL: displayMode = switchMode (any value 0–7). btnNext pulses are ignored.
- btnNext path:
  - Two-flop synchronizer.
  - The debounced level flips after the synchronized input has differed from it for DEBOUNCE_CYCLES consecutive cycles; any agreement clears the counter.
  - A one-cycle pulse is generated on the debounced 0→1 edge only.
- Counters are 32-bit, unsigned, with no overflow beyond the parameter bounds.

## Timing
- Input change at edge N → state/displayMode/owner valid after edge N+1 (1-cycle latency).
- modeChanged is asserted in the cycle after displayMode takes its new value; it is never asserted when a re-arbitration keeps the same mode.
- Button latency: raw press stable → pulse after 2 + DEBOUNCE_CYCLES edges; mode advance one edge later.
- Auto dwell: each mode is held exactly DWELL_CYCLES cycles absent button pulses.
- Alert duration: at least ALERT_HOLD_CYCLES cycles; the exit edge is the first edge with the counter at 0 and thermalThrottle=0.
- Reset asserted mid-operation: all outputs take their reset values at the next edge, regardless of state.

## Test plan
Parameter overrides: DWELL_CYCLES=8, ALERT_HOLD_CYCLES=4, DEBOUNCE_CYCLES=3.
- Reset, then clockLocked=1 with switchMode=2 → owner 1 and displayMode 2 one cycle later; modeValid=1; modeChanged pulses once.
- autoCycle=1 → displayMode sequence 0,1,2,3,4,0, each held exactly 8 cycles; modes 5–7 never appear.
- In AUTO, hold btnNext high 10 cycles:
  - → exactly one advance, 6 cycles after the press.
  - A 2-cycle glitch → no advance.
  - A press timed so its pulse coincides with dwell expiry → advance by 1.
- In DEMO, thermalThrottle pulses high for 1 cycle → owner 4 and displayMode 0 for exactly 4 cycles, then owner 3. With thermalThrottle held high, ALERT persists until it drops.
- Set demoActive=1 while in AUTO at index 3 → displayMode 3/4 following demoPhase[0]. Set demoActive=0 → AUTO resumes at index 3 with a full 8-cycle dwell.
- Drop clockLocked in ALERT → INIT with displayMode 7 and modeValid=0 next cycle. Assert reset mid-AUTO → reset values next edge and auto index 0.

Source files
------------

// File: rtl/led_mode_scheduler.sv
// Arbitrates the LED display controller's mode select between manual, auto-cycle,
// demo and alert requesters; all outputs are registered.
module led_mode_scheduler #(
  parameter int unsigned DWELL_CYCLES      = 100000000,
  parameter int unsigned ALERT_HOLD_CYCLES = 50000000,
  parameter int unsigned DEBOUNCE_CYCLES   = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] switchMode,
  input  logic       autoCycle,
  input  logic       btnNext,
  input  logic       clockLocked,
  input  logic       thermalThrottle,
  input  logic       demoActive,
  input  logic [2:0] demoPhase,
  output logic [2:0] displayMode,
  output logic [2:0] owner,
  output logic       modeValid,
  output logic       alertActive,
  output logic       modeChanged
);

  localparam int unsigned CNT_W = 32;
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(ALERT_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [2:0]       IDX_LAST   = 3'd4;
  localparam logic [2:0]       MODE_HEARTBEAT = 3'd7;

  typedef enum logic [2:0] {
    S_INIT   = 3'd0,
    S_MANUAL = 3'd1,
    S_AUTO   = 3'd2,
    S_DEMO   = 3'd3,
    S_ALERT  = 3'd4
  } state_t;

  state_t            state_q, state_d, arb_state;
  logic              btn_meta, btn_sync, btn_db, btn_pulse;
  logic [CNT_W-1:0]  db_cnt;
  logic              thr_prev, thr_rise;
  logic [CNT_W-1:0]  hold_q, hold_d;
  logic [CNT_W-1:0]  dwell_q, dwell_d;
  logic [2:0]        auto_idx_q, auto_idx_d;
  logic [2:0]        mode_d, owner_d, mode_prev;
  logic              valid_d, alert_d;
  logic              unused_demo_bits;

  assign unused_demo_bits = ^demoPhase[2:1];
  assign thr_rise = thermalThrottle & ~thr_prev;

  // Button synchronizer, debouncer and rising-edge pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      btn_meta  <= 1'b0;
      btn_sync  <= 1'b0;
      btn_db    <= 1'b0;
      btn_pulse <= 1'b0;
      db_cnt    <= '0;
      thr_prev  <= 1'b0;
    end else begin
      btn_meta  <= btnNext;
      btn_sync  <= btn_meta;
      btn_pulse <= 1'b0;
      thr_prev  <= thermalThrottle;
      if (btn_sync != btn_db) begin
        if (db_cnt == DB_LAST) begin
          btn_db    <= btn_sync;
          btn_pulse <= btn_sync;
          db_cnt    <= '0;
        end else begin
          db_cnt <= db_cnt + 1'b1;
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_INIT;
    else       state_q <= state_d;
  end

  // Next-state: lock loss beats everything, an alert holds until released
  always_comb begin
    arb_state = S_MANUAL;
    if (demoActive)     arb_state = S_DEMO;
    else if (autoCycle) arb_state = S_AUTO;
    state_d = state_q;
    if (!clockLocked) begin
      state_d = S_INIT;
    end else if (thr_rise) begin
      state_d = S_ALERT;
    end else if (state_q == S_ALERT) begin
      if (hold_q == '0 && !thermalThrottle) state_d = arb_state;
    end else begin
      state_d = arb_state;
    end
  end

  // Auto tour index, dwell and alert hold counters
  always_comb begin
    auto_idx_d = auto_idx_q;
    dwell_d    = dwell_q;
    hold_d     = hold_q;
    if (state_d == S_AUTO) begin
      if (state_q != S_AUTO) begin
        dwell_d = '0;
      end else if (btn_pulse || dwell_q == DWELL_LAST) begin
        dwell_d    = '0;
        auto_idx_d = (auto_idx_q == IDX_LAST) ? 3'd0 : auto_idx_q + 3'd1;
      end else begin
        dwell_d = dwell_q + 1'b1;
      end
    end
    if (state_d == S_ALERT) begin
      if (state_q != S_ALERT || thr_rise) hold_d = HOLD_LAST;
      else if (hold_q != '0)              hold_d = hold_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      auto_idx_q <= '0;
      dwell_q    <= '0;
      hold_q     <= '0;
    end else begin
      auto_idx_q <= auto_idx_d;
      dwell_q    <= dwell_d;
      hold_q     <= hold_d;
    end
  end

  // Output decode from the upcoming state so mode and state move together
  always_comb begin
    mode_d  = MODE_HEARTBEAT;
    owner_d = 3'(state_d);
    valid_d = 1'b1;
    alert_d = 1'b0;
    case (state_d)
      S_INIT:   valid_d = 1'b0;
      S_MANUAL: mode_d  = switchMode;
      S_AUTO:   mode_d  = auto_idx_d;
      S_DEMO:   mode_d  = demoPhase[0] ? 3'd4 : 3'd3;
      S_ALERT: begin
        mode_d  = 3'd0;
        alert_d = 1'b1;
      end
      default: begin
        mode_d  = MODE_HEARTBEAT;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      displayMode <= MODE_HEARTBEAT;
      mode_prev   <= MODE_HEARTBEAT;
      owner       <= 3'd0;
      modeValid   <= 1'b0;
      alertActive <= 1'b0;
      modeChanged <= 1'b0;
    end else begin
      displayMode <= mode_d;
      mode_prev   <= displayMode;
      owner       <= owner_d;
      modeValid   <= valid_d;
      alertActive <= alert_d;
      modeChanged <= (displayMode != mode_prev);
    end
  end

endmodule

// File: tb/tb_led_mode_scheduler.sv
// Directed bench for led_mode_scheduler with short dwell/hold/debounce parameters.
module tb_led_mode_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] switchMode;
  logic       autoCycle;
  logic       btnNext;
  logic       clockLocked;
  logic       thermalThrottle;
  logic       demoActive;
  logic [2:0] demoPhase;
  logic [2:0] displayMode;
  logic [2:0] owner;
  logic       modeValid;
  logic       alertActive;
  logic       modeChanged;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  led_mode_scheduler #(
    .DWELL_CYCLES     (8),
    .ALERT_HOLD_CYCLES(4),
    .DEBOUNCE_CYCLES  (3)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .switchMode     (switchMode),
    .autoCycle      (autoCycle),
    .btnNext        (btnNext),
    .clockLocked    (clockLocked),
    .thermalThrottle(thermalThrottle),
    .demoActive     (demoActive),
    .demoPhase      (demoPhase),
    .displayMode    (displayMode),
    .owner          (owner),
    .modeValid      (modeValid),
    .alertActive    (alertActive),
    .modeChanged    (modeChanged)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  // Advance one edge; sample 1 time unit after it
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_to(input int n);
    while (cyc < n) step();
  endtask

  initial begin
    reset = 1'b1; switchMode = 3'd0; autoCycle = 1'b0; btnNext = 1'b0;
    clockLocked = 1'b0; thermalThrottle = 1'b0; demoActive = 1'b0; demoPhase = 3'd0;
    step(); step();
    check("rst_mode",    32'(displayMode), 32'd7);
    check("rst_owner",   32'(owner),       32'd0);
    check("rst_valid",   32'(modeValid),   32'd0);
    check("rst_alert",   32'(alertActive), 32'd0);
    check("rst_changed", 32'(modeChanged), 32'd0);

    reset = 1'b0;
    step();
    check("init_unlocked", 32'(displayMode), 32'd7);

    clockLocked = 1'b1; switchMode = 3'd2;
    step();
    check("man_owner", 32'(owner),       32'd1);
    check("man_mode",  32'(displayMode), 32'd2);
    check("man_valid", 32'(modeValid),   32'd1);
    check("man_chg0",  32'(modeChanged), 32'd0);
    step();
    check("man_chg1",  32'(modeChanged), 32'd1);
    step();
    check("man_chg2",  32'(modeChanged), 32'd0);

    // Auto tour: cyc counts edges since AUTO entry
    autoCycle = 1'b1;
    step();
    cyc = 0;
    check("auto_owner", 32'(owner), 32'd2);
    for (int k = 0; k < 48; k++) begin
      wait_to(k);
      check("tour", 32'(displayMode), 32'((k / 8) % 5));
    end

    // Held press: one advance six edges later, none on release
    wait_to(48); btnNext = 1'b1;
    wait_to(53); check("btn_pre",  32'(displayMode), 32'd1);
    wait_to(54); check("btn_adv",  32'(displayMode), 32'd2);
    wait_to(58); btnNext = 1'b0;
    wait_to(61); check("btn_once", 32'(displayMode), 32'd2);
    wait_to(62); check("dwell_after_btn", 32'(displayMode), 32'd3);
    wait_to(70); check("dwell_to4", 32'(displayMode), 32'd4);

    // Two-cycle glitch must not advance
    wait_to(71); btnNext = 1'b1;
    wait_to(73); btnNext = 1'b0;
    wait_to(77); check("glitch_none", 32'(displayMode), 32'd4);
    wait_to(78); check("wrap_to0",    32'(displayMode), 32'd0);

    // Press whose pulse lands on dwell expiry advances by one
    wait_to(80); btnNext = 1'b1;
    wait_to(85); check("coin_pre",   32'(displayMode), 32'd0);
    wait_to(86); check("coin_adv1",  32'(displayMode), 32'd1);
    wait_to(90); btnNext = 1'b0;
    wait_to(93); check("coin_hold",  32'(displayMode), 32'd1);
    wait_to(94); check("coin_next",  32'(displayMode), 32'd2);

    // Demo takes over at index 3
    wait_to(102); check("idx3", 32'(displayMode), 32'd3);
    wait_to(104); demoActive = 1'b1; demoPhase = 3'd0;
    wait_to(105); check("demo_owner", 32'(owner), 32'd3);
    check("demo_ph0", 32'(displayMode), 32'd3);
    demoPhase = 3'd1;
    wait_to(106); check("demo_ph1", 32'(displayMode), 32'd4);
    demoPhase = 3'd2;
    wait_to(107); check("demo_ph2", 32'(displayMode), 32'd3);

    // One-cycle throttle pulse: four cycles of alert
    thermalThrottle = 1'b1;
    wait_to(108); thermalThrottle = 1'b0;
    check("alert_mode",  32'(displayMode), 32'd0);
    check("alert_flag",  32'(alertActive), 32'd1);
    for (int k = 108; k < 112; k++) begin
      wait_to(k);
      check("alert_hold", 32'(owner), 32'd4);
    end
    wait_to(112); check("alert_exit", 32'(owner), 32'd3);

    // Held throttle keeps alert until it drops
    thermalThrottle = 1'b1;
    wait_to(113); check("alert2_in",   32'(owner), 32'd4);
    wait_to(120); check("alert2_hold", 32'(alertActive), 32'd1);
    thermalThrottle = 1'b0;
    wait_to(121); check("alert2_exit", 32'(owner), 32'd3);
    demoActive = 1'b0;
    wait_to(122); check("resume_owner", 32'(owner), 32'd2);
    check("resume_idx", 32'(displayMode), 32'd3);
    check("chg_after_alert", 32'(modeChanged), 32'd1);
    wait_to(123); check("chg_same_mode", 32'(modeChanged), 32'd0);
    wait_to(129); check("resume_dwell", 32'(displayMode), 32'd3);
    wait_to(130); check("resume_adv", 32'(displayMode), 32'd4);
    wait_to(131); check("chg_pulse", 32'(modeChanged), 32'd1);
    wait_to(132); check("chg_clear", 32'(modeChanged), 32'd0);

    // Lock loss inside alert
    thermalThrottle = 1'b1;
    wait_to(134); check("alert3", 32'(owner), 32'd4);
    clockLocked = 1'b0;
    wait_to(135); check("unlock_mode",  32'(displayMode), 32'd7);
    check("unlock_valid", 32'(modeValid),   32'd0);
    check("unlock_owner", 32'(owner),       32'd0);
    check("unlock_alert", 32'(alertActive), 32'd0);
    clockLocked = 1'b1; thermalThrottle = 1'b0;
    wait_to(136); check("relock_owner", 32'(owner), 32'd2);
    check("relock_idx", 32'(displayMode), 32'd4);

    // Reset mid-AUTO clears outputs and the tour index
    wait_to(138); reset = 1'b1;
    wait_to(139); check("mrst_mode",  32'(displayMode), 32'd7);
    check("mrst_owner", 32'(owner),       32'd0);
    check("mrst_valid", 32'(modeValid),   32'd0);
    check("mrst_chg",   32'(modeChanged), 32'd0);
    reset = 1'b0;
    wait_to(140); check("mrst_idx0", 32'(displayMode), 32'd0);
    check("mrst_auto", 32'(owner), 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
